// File: rtl/mips_alu_pkg.sv
// Shared encodings for the pipelined MIPS ALU: op_alu/funct codes, decoded operation, FSM states.
package mips_alu_pkg;

  localparam logic [1:0] OPALU_ADD   = 2'b00;
  localparam logic [1:0] OPALU_SUB   = 2'b01;
  localparam logic [1:0] OPALU_FUNCT = 2'b10;
  localparam logic [1:0] OPALU_PASSB = 2'b11;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT,
    ALU_MULTU,
    ALU_PASSB,
    ALU_ILL
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/mips_alu_pipe_if.sv
// Operand/result handshake bundle for mips_alu_pipe; master is the register-read side, slave the ALU.
interface mips_alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op_alu;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, op_alu, funct, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, illegal
  );

  modport slave (
    input  in_valid, op_alu, funct, a, b, out_ready,
    output in_ready, out_valid, result, result_hi, zero, illegal
  );
endinterface

// File: rtl/mips_alu_decode.sv
// Combinational ALU control: maps op_alu and the R-type funct field onto one internal operation.
module mips_alu_decode
  import mips_alu_pkg::*;
(
  input  logic [1:0] op_alu_i,
  input  logic [5:0] funct_i,
  output alu_op_t    op_o
);

  // NOTE: op_o is defaulted before the case so every path assigns it and no latch is inferred.
  always_comb begin
    op_o = ALU_ILL;
    case (op_alu_i)
      OPALU_ADD:   op_o = ALU_ADD;
      OPALU_SUB:   op_o = ALU_SUB;
      OPALU_PASSB: op_o = ALU_PASSB;
      OPALU_FUNCT: begin
        case (funct_i)
          FUNCT_ADD:   op_o = ALU_ADD;
          FUNCT_SUB:   op_o = ALU_SUB;
          FUNCT_AND:   op_o = ALU_AND;
          FUNCT_OR:    op_o = ALU_OR;
          FUNCT_NOR:   op_o = ALU_NOR;
          FUNCT_SLT:   op_o = ALU_SLT;
          FUNCT_MULTU: op_o = ALU_MULTU;
          default:     op_o = ALU_ILL;
        endcase
      end
      default:     op_o = ALU_ILL;
    endcase
  end

endmodule

// File: rtl/mips_alu_pipe.sv
// Pipelined MIPS ALU with valid/ready on both sides, registered results and a 1-bit/cycle MULTU.
// Define MIPS_ALU_OVF_EN to add a registered signed-overflow output (ovf) for add/sub.
module mips_alu_pipe
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mips_alu_pipe_if.slave bus
`ifdef MIPS_ALU_OVF_EN
  ,
  output logic           ovf
`endif
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  alu_op_t            op;
  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] step_prod;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   ex_result;
  logic               in_ready;
  logic               accept;
`ifdef MIPS_ALU_OVF_EN
  logic               ovf_q, ovf_d;
  logic               ex_ovf;
`endif

  mips_alu_decode u_decode (
    .op_alu_i (bus.op_alu),
    .funct_i  (bus.funct),
    .op_o     (op)
  );

  // Depends only on registered state and out_ready, never on in_valid.
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    ex_result = '0;
    case (op)
      ALU_ADD:   ex_result = bus.a + bus.b;
      ALU_SUB:   ex_result = bus.a - bus.b;
      ALU_AND:   ex_result = bus.a & bus.b;
      ALU_OR:    ex_result = bus.a | bus.b;
      ALU_NOR:   ex_result = ~(bus.a | bus.b);
      ALU_SLT:   ex_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      ALU_PASSB: ex_result = bus.b;
      default:   ex_result = '0;
    endcase
  end

`ifdef MIPS_ALU_OVF_EN
  always_comb begin
    ex_ovf = 1'b0;
    if (op == ALU_ADD) begin
      ex_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (ex_result[WIDTH-1] != bus.a[WIDTH-1]);
    end else if (op == ALU_SUB) begin
      ex_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (ex_result[WIDTH-1] != bus.a[WIDTH-1]);
    end
  end
`endif

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  assign step_prod = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    out_valid_d = (out_valid_q && bus.out_ready) ? 1'b0 : out_valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
`ifdef MIPS_ALU_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == ALU_MULTU) begin
            state_d  = ST_MUL;
            mcand_d  = {{WIDTH{1'b0}}, bus.a};
            mplier_d = bus.b;
            prod_d   = '0;
            cnt_d    = '0;
          end else begin
            out_valid_d = 1'b1;
            result_d    = ex_result;
            result_hi_d = '0;
            zero_d      = (ex_result == '0);
            illegal_d   = (op == ALU_ILL);
`ifdef MIPS_ALU_OVF_EN
            ovf_d       = ex_ovf;
`endif
          end
        end else if (out_valid_q && !bus.out_ready) begin
          state_d = ST_HOLD;
        end
      end
      ST_MUL: begin
        prod_d   = step_prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          result_d    = step_prod[WIDTH-1:0];
          result_hi_d = step_prod[2*WIDTH-1:WIDTH];
          zero_d      = (step_prod == '0);
          illegal_d   = 1'b0;
`ifdef MIPS_ALU_OVF_EN
          ovf_d       = 1'b0;
`endif
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
`ifdef MIPS_ALU_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
`ifdef MIPS_ALU_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
`ifdef MIPS_ALU_OVF_EN
  assign ovf           = ovf_q;
`endif

endmodule
